serial_add_sched: RTL and testbench

Bit-serial adder scheduler that shares a single 1-bit adder cell, built from two half adders, between two requesters. Each requester hands over a WIDTH-bit operand pair through a valid/ready handshake. The block arbitrates round-robin, steps the operands LSB-first through the shared cell with a carry register, and returns a WIDTH+1-bit sum tagged with the requester id. It sits between the pin-level input decoding and the output register stage of the adder demo.

---
 rtl/serial_add_pkg.sv | 15 +
 rtl/serial_add_cell.sv | 21 ++
 rtl/serial_add_sched.sv | 125 ++++++++++++
 tb/tb_serial_add_sched.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder scheduler: FSM states,
// requester id width and the legal operand width range.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int ID_W      = 1;
    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 8;

endpackage

// File: rtl/serial_add_cell.sv
// One-bit full adder built from two cascaded half-adder stages; shared by
// both requesters through the scheduler.
module serial_add_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p, g1, g2;

    always_comb begin
        p    = a ^ b;
        g1   = a & b;
        s    = p ^ cin;
        g2   = p & cin;
        cout = g1 | g2;
    end

endmodule

// File: rtl/serial_add_sched.sv
// Round-robin scheduler feeding two requesters' operand pairs LSB-first
// through a single shared 1-bit adder cell; returns a WIDTH+1-bit sum.
module serial_add_sched
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH:0]   res_sum,
    output logic             res_id,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [WIDTH:0]    sum_q, sum_d;
    logic              carry_q, carry_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              last_q, last_d;

    logic              grant0, grant1;
    logic              cell_s, cell_c;
    logic [WIDTH-1:0]  sum_lo;

    serial_add_cell u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (cell_s),
        .cout (cell_c)
    );

    // last_q holds the id granted most recently; on a tie the other one wins
    always_comb begin
        grant0     = req0_valid & (~req1_valid | last_q);
        grant1     = req1_valid & (~req0_valid | ~last_q);
        req0_ready = (state_q == ST_IDLE) & grant0;
        req1_ready = (state_q == ST_IDLE) & grant1;
        res_valid  = (state_q == ST_DONE);
        busy       = (state_q != ST_IDLE);
        res_sum    = sum_q;
        res_id     = id_q;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        last_d  = last_q;

        sum_lo            = sum_q[WIDTH-1:0] >> 1;
        sum_lo[WIDTH-1]   = cell_s;

        case (state_q)
            ST_IDLE: begin
                if (grant0 | grant1) begin
                    a_d     = grant1 ? req1_a : req0_a;
                    b_d     = grant1 ? req1_b : req0_b;
                    sum_d   = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    id_d    = grant1;
                    last_d  = grant1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d               = a_q >> 1;
                b_d               = b_q >> 1;
                carry_d           = cell_c;
                cnt_d             = cnt_q + CNT_W'(1);
                sum_d[WIDTH-1:0]  = sum_lo;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    sum_d[WIDTH] = cell_c;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            id_q    <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_serial_add_sched.sv
// Directed bench for serial_add_sched: a WIDTH=4 instance for the main
// scenarios and a WIDTH=1 instance for the single-bit build.
module tb_serial_add_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0, res_ready = 1'b1;
    logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic       req0_ready, req1_ready, res_valid, res_id, busy;
    logic [4:0] res_sum;

    logic       w_req0_valid = 1'b0, w_req1_valid = 1'b0, w_res_ready = 1'b1;
    logic [0:0] w_req0_a = '0, w_req0_b = '0, w_req1_a = '0, w_req1_b = '0;
    logic       w_req0_ready, w_req1_ready, w_res_valid, w_res_id, w_busy;
    logic [1:0] w_res_sum;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [8:0] sum;
        logic       id;
    } exp_t;

    exp_t sb[$];
    exp_t sb1[$];

    logic [3:0] p0a [2] = '{4'h1, 4'h5};
    logic [3:0] p0b [2] = '{4'h2, 4'h6};
    logic [3:0] p1a [2] = '{4'h7, 4'hA};
    logic [3:0] p1b [2] = '{4'h9, 4'h3};

    always #5 clk = ~clk;

    serial_add_sched #(.WIDTH(4)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_id(res_id),
        .busy(busy)
    );

    serial_add_sched #(.WIDTH(1)) u_dut_w1 (
        .clk(clk), .rst(rst),
        .req0_valid(w_req0_valid), .req0_ready(w_req0_ready), .req0_a(w_req0_a), .req0_b(w_req0_b),
        .req1_valid(w_req1_valid), .req1_ready(w_req1_ready), .req1_a(w_req1_a), .req1_b(w_req1_b),
        .res_valid(w_res_valid), .res_ready(w_res_ready), .res_sum(w_res_sum), .res_id(w_res_id),
        .busy(w_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic accept(input int id, input logic [3:0] a, input logic [3:0] b, output int waits);
        if (id == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        else         begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        waits = 0;
        #1;
        while (!((id == 0) ? req0_ready : req1_ready) && waits < 50) begin
            @(negedge clk); #1; waits++;
        end
        chk("grant_seen", waits < 50, 1);
        sb.push_back('{sum: 9'(a) + 9'(b), id: id[0]});
        @(posedge clk);
        @(negedge clk);
        if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    // Entered at the negedge after the accepting edge; lat counts that sample as 1.
    task automatic wait_result(output int lat, output int busy_n);
        exp_t e;
        lat    = 1;
        busy_n = int'(busy);
        while (!res_valid && lat < 60) begin
            @(negedge clk); lat++; busy_n += int'(busy);
        end
        chk("res_valid_seen", res_valid, 1);
        chk("sb_depth", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("res_sum", res_sum, e.sum);
            chk("res_id", res_id, e.id);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int   w, lat, bn, g, k0, k1;
        logic seen;
        exp_t e;

        // reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_sum", res_sum, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_w1_busy", w_busy, 0);

        // single request on requester 0
        @(negedge clk);
        accept(0, 4'h3, 4'h5, w);
        chk("t1_ready_same_cycle", w, 0);
        wait_result(lat, bn);
        chk("t1_latency", lat, 5);
        @(negedge clk);
        chk("t1_res_valid_low", res_valid, 0);
        chk("t1_busy_low", busy, 0);

        // max operands on requester 1
        accept(1, 4'hF, 4'hF, w);
        wait_result(lat, bn);
        chk("t2_latency", lat, 5);
        chk("t2_busy_cycles", bn, 5);
        @(negedge clk);
        chk("t2_busy_low", busy, 0);

        // simultaneous requests after a fresh reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        k0 = 0; k1 = 0;
        req0_valid = 1'b1; req0_a = p0a[0]; req0_b = p0b[0];
        req1_valid = 1'b1; req1_a = p1a[0]; req1_b = p1b[0];
        for (int i = 0; i < 4; i++) begin
            w = 0;
            #1;
            while (!(req0_ready | req1_ready) && w < 50) begin
                @(negedge clk); #1; w++;
            end
            chk("t3_onehot", {req0_ready, req1_ready} != 2'b11, 1);
            g = int'(req1_ready);
            chk("t3_order", g, i % 2);
            if (g == 0) sb.push_back('{sum: 9'(req0_a) + 9'(req0_b), id: 1'b0});
            else        sb.push_back('{sum: 9'(req1_a) + 9'(req1_b), id: 1'b1});
            @(posedge clk);
            @(negedge clk);
            if (g == 0) begin
                k0++;
                if (k0 < 2) begin req0_a = p0a[k0]; req0_b = p0b[k0]; end
                else req0_valid = 1'b0;
            end else begin
                k1++;
                if (k1 < 2) begin req1_a = p1a[k1]; req1_b = p1b[k1]; end
                else req1_valid = 1'b0;
            end
            wait_result(lat, bn);
        end
        @(negedge clk);

        // backpressure
        res_ready = 1'b0;
        accept(0, 4'h9, 4'h8, w);
        wait_result(lat, bn);
        req1_valid = 1'b1; req1_a = 4'h2; req1_b = 4'h2;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("t4_hold_valid", res_valid, 1);
            chk("t4_hold_sum", res_sum, 5'h11);
            chk("t4_hold_id", res_id, 0);
            chk("t4_no_ready", {req0_ready, req1_ready}, 0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("t4_idle_after_hs", busy, 0);
        chk("t4_next_ready", req1_ready, 1);
        sb.push_back('{sum: 9'h004, id: 1'b1});
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        wait_result(lat, bn);
        @(negedge clk);

        // reset on the second RUN cycle
        accept(0, 4'h5, 4'h6, w);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_res_valid", res_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_res_sum", res_sum, 0);
        chk("t5_res_id", res_id, 0);
        sb.delete();
        seen = 1'b0;
        repeat (8) begin @(negedge clk); seen |= res_valid; end
        chk("t5_no_result", seen, 0);
        // tie right after reset must go to requester 0
        req0_valid = 1'b1; req0_a = 4'h4; req0_b = 4'h4;
        req1_valid = 1'b1; req1_a = 4'h1; req1_b = 4'h1;
        #1;
        chk("t5_tie_r0", req0_ready, 1);
        chk("t5_tie_r1", req1_ready, 0);
        sb.push_back('{sum: 9'h008, id: 1'b0});
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_result(lat, bn);
        chk("t5_latency", lat, 5);
        @(negedge clk);

        // WIDTH=1 instance
        for (int i = 0; i < 4; i++) begin
            logic ba, bb;
            ba = i[1]; bb = i[0];
            w_req0_valid = 1'b1; w_req0_a = ba; w_req0_b = bb;
            #1;
            chk("w1_ready", w_req0_ready, 1);
            sb1.push_back('{sum: {7'b0, ba & bb, ba ^ bb}, id: 1'b0});
            @(posedge clk);
            @(negedge clk);
            w_req0_valid = 1'b0;
            lat = 1;
            while (!w_res_valid && lat < 20) begin @(negedge clk); lat++; end
            chk("w1_latency", lat, 2);
            e = sb1.pop_front();
            chk("w1_sum", w_res_sum, e.sum);
            chk("w1_id", w_res_id, e.id);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
